// File: rtl/vdp_bridge_pkg.sv
// Shared types for the VDP host-bus bridge: FSM state encoding, posted-write entry and bit-order helper.
package vdp_bridge_pkg;

   // Entry fields are sized by these; the bridge's ADDR_W/DATA_W default to them and must match.
   localparam int unsigned BRIDGE_ADDR_W = 2;
   localparam int unsigned BRIDGE_DATA_W = 8;
   localparam int unsigned REV_MAX_W     = 32;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      RD_DRAIN,
      RD_REQ,
      RD_HOLD
   } bridge_state_t;

   typedef struct packed {
      logic [BRIDGE_ADDR_W-1:0] adr;
      logic [BRIDGE_DATA_W-1:0] data;
   } fifo_entry_t;

   // Mirrors the low 'width' bits (TI numbering has bit 0 as the MSB).
   function automatic logic [REV_MAX_W-1:0] bit_rev(input logic [REV_MAX_W-1:0] d, input int width);
      logic [REV_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(REV_MAX_W); i++)
         if (i < width) r[i] = d[width-1-i];
      return r;
   endfunction

endpackage

// File: rtl/vdp_bridge_fifo.sv
// Posted-write FIFO for the VDP bridge: synchronous push/pop with occupancy level, full and empty.
module vdp_bridge_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == (PTR_W+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // NOTE: the array has no reset on purpose; level and pointers alone decide what is valid, so it maps to plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (PTR_W+1)'(1);
            2'b01:   level <= level - (PTR_W+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/vdp_cpu_bridge.sv
// Host-bus front end for the VDP: filters csr_n/csw_n, posts writes, orders reads behind them.
// Optional ack timeout is enabled by defining VDP_BRIDGE_ACK_TIMEOUT_EN.
module vdp_cpu_bridge
   import vdp_bridge_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = BRIDGE_ADDR_W,
   parameter int DATA_W      = BRIDGE_DATA_W,
   parameter int FIFO_DEPTH  = 4,
   parameter int BIT_REVERSE = 1,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          csr_n,
   input  logic                          csw_n,
   input  logic [ADDR_W-1:0]             mode,
   input  logic [DATA_W-1:0]             cd_in,
   output logic [DATA_W-1:0]             cd_out,
   output logic                          cd_oe,
   output logic                          vdp_req,
   output logic                          vdp_wrt,
   output logic [ADDR_W-1:0]             vdp_adr,
   output logic [DATA_W-1:0]             vdp_dbo,
   input  logic                          vdp_ack,
   input  logic [DATA_W-1:0]             vdp_dbi,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          overflow_clr,
   output logic                          bus_err
);

   localparam int LAST = SYNC_STAGES - 1;

   function automatic logic [DATA_W-1:0] host_order(input logic [DATA_W-1:0] d);
      return (BIT_REVERSE != 0) ? DATA_W'(bit_rev(REV_MAX_W'(d), DATA_W)) : d;
   endfunction

   logic [SYNC_STAGES-1:0] csr_sync, csw_sync;
   logic [ADDR_W-1:0]      mode_sync [SYNC_STAGES];
   logic [DATA_W-1:0]      cd_sync   [SYNC_STAGES];
   logic                   rd_act, wr_act, rd_act_next, wr_act_next;
   logic                   rd_start, wr_start, wr_end, conflict, conflict_start;
   logic                   wr_spoiled, rd_pend;
   logic [ADDR_W-1:0]      wr_adr, rd_mode;
   bridge_state_t          state, next_state;
   logic                   done, timeout, pop, load_wr, load_rd, latch_rd;
   logic                   push, full, empty;
   fifo_entry_t            push_entry, head;

   always_ff @(posedge clk) begin
      if (reset) begin
         csr_sync <= '1;
         csw_sync <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            mode_sync[i] <= '0;
            cd_sync[i]   <= '0;
         end
      end else begin
         csr_sync     <= {csr_sync[SYNC_STAGES-2:0], csr_n};
         csw_sync     <= {csw_sync[SYNC_STAGES-2:0], csw_n};
         mode_sync[0] <= mode;
         cd_sync[0]   <= cd_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            mode_sync[i] <= mode_sync[i-1];
            cd_sync[i]   <= cd_sync[i-1];
         end
      end
   end

   // Hysteresis: the filtered level only moves when the last two stages agree.
   assign rd_act_next    = (csr_sync[LAST] == csr_sync[LAST-1]) ? ~csr_sync[LAST] : rd_act;
   assign wr_act_next    = (csw_sync[LAST] == csw_sync[LAST-1]) ? ~csw_sync[LAST] : wr_act;
   assign conflict       = rd_act_next & wr_act_next;
   assign conflict_start = conflict & ~(rd_act & wr_act);
   assign rd_start       = rd_act_next & ~rd_act & ~wr_act_next;
   assign wr_start       = wr_act_next & ~wr_act;
   assign wr_end         = ~wr_act_next & wr_act;
   assign push           = wr_end & ~wr_spoiled;

   assign push_entry.adr  = wr_adr;
   assign push_entry.data = host_order(cd_sync[LAST]);

   vdp_bridge_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fifo_entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

`ifdef VDP_BRIDGE_ACK_TIMEOUT_EN
   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge clk) begin
      if (reset || !vdp_req) tmo_cnt <= '0;
      else                   tmo_cnt <= tmo_cnt + TMO_W'(1);
   end

   assign timeout = vdp_req & (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
`else
   assign timeout = 1'b0;
`endif

   assign done    = vdp_req & (vdp_ack | timeout);
   assign vdp_req = (state == WR_REQ) || (state == RD_REQ);
   assign vdp_wrt = (state == WR_REQ);

   // The head entry stays in the FIFO until the VDP takes it, so level counts the in-flight write.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      next_state = state;
      pop        = 1'b0;
      load_wr    = 1'b0;
      load_rd    = 1'b0;
      latch_rd   = 1'b0;
      case (state)
         IDLE: begin
            if (rd_pend)     next_state = RD_DRAIN;
            else if (!empty) begin
               load_wr    = 1'b1;
               next_state = WR_REQ;
            end
         end
         WR_REQ: begin
            if (done) begin
               pop        = 1'b1;
               next_state = rd_pend ? RD_DRAIN : IDLE;
            end
         end
         RD_DRAIN: begin
            if (!empty) begin
               load_wr    = 1'b1;
               next_state = WR_REQ;
            end else begin
               load_rd    = 1'b1;
               next_state = RD_REQ;
            end
         end
         RD_REQ: begin
            if (done) begin
               latch_rd   = 1'b1;
               next_state = rd_act ? RD_HOLD : IDLE;
            end
         end
         RD_HOLD: if (!rd_act) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rd_act     <= 1'b0;
         wr_act     <= 1'b0;
         wr_spoiled <= 1'b0;
         rd_pend    <= 1'b0;
         wr_adr     <= '0;
         rd_mode    <= '0;
         vdp_adr    <= '0;
         vdp_dbo    <= '0;
         cd_out     <= '0;
         overflow   <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         state   <= next_state;
         rd_act  <= rd_act_next;
         wr_act  <= wr_act_next;
         bus_err <= conflict_start | timeout;

         if (wr_start) begin
            wr_adr     <= mode_sync[LAST];
            wr_spoiled <= conflict;
         end else if (conflict) begin
            wr_spoiled <= 1'b1;
         end

         if (rd_start) begin
            rd_pend <= 1'b1;
            rd_mode <= mode_sync[LAST];
         end else if (load_rd) begin
            rd_pend <= 1'b0;
         end

         if (load_wr) begin
            vdp_adr <= ADDR_W'(head.adr);
            vdp_dbo <= DATA_W'(head.data);
         end else if (load_rd) begin
            vdp_adr <= rd_mode;
         end

         if (latch_rd) cd_out <= timeout ? '1 : host_order(vdp_dbi);

         if (push && full)      overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
      end
   end

   assign cd_oe = rd_act;

endmodule
